// File: rtl/rr_arb16_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb16_pkg
// Shared definitions for the 16-way round-robin arbiter:
//   - state_t : arbiter FSM states (S_IDLE, S_GRANT)
//   - NREQ    : number of requesters
//   - IDX_W   : width of a requester index
//   - HOLD_W  : width of the grant hold counter
// ----------------------------------------------------------------------------
package rr_arb16_pkg;

    localparam int NREQ   = 16;
    localparam int IDX_W  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

endpackage : rr_arb16_pkg

// File: rtl/rr_arb16_dec4_16.sv
// ----------------------------------------------------------------------------
// dec4_16
// 4-to-16 one-hot decoder with enable. When the enable is low the output is
// all zero, so a cleared grant-valid produces an all-zero grant vector.
// Ports:
//   a   : in  [3:0]  binary index
//   enn : in         enable (output active when high)
//   d   : out [15:0] one-hot decode of a, or zero when disabled
// ----------------------------------------------------------------------------
module dec4_16
    import rr_arb16_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    input  logic             enn,
    output logic [NREQ-1:0]  d
);

    always_comb begin
        d = '0;
        if (enn) begin
            d[a] = 1'b1;
        end
    end

endmodule : dec4_16

// File: rtl/rr_arb16.sv
// ----------------------------------------------------------------------------
// rr_arb16
// 16-requester round-robin arbiter with a bounded hold time.
// A grant is issued one cycle after a request is seen in IDLE. The grant is
// held until the grantee signals done, drops its request (abandon) or has
// held the resource for MAX_HOLD cycles (forced revoke, flagged by a
// one-cycle timeout pulse). Every grant is followed by one IDLE cycle, and
// the search pointer moves past the last grantee so service rotates fairly.
//
// Parameters:
//   MAX_HOLD : maximum grant length in cycles (1..255)
// Ports:
//   clk     : in         clock, rising edge
//   rst     : in         synchronous active-high reset
//   req     : in  [15:0] request vector, bit i = requester i
//   done    : in         grantee releases the resource (used only in GRANT)
//   gnt     : out [15:0] one-hot grant, zero when no grant is held
//   gnt_idx : out [3:0]  registered index of the grantee
//   gnt_vld : out        registered grant-held flag
//   timeout : out        registered one-cycle pulse after a forced revoke
//
// Handshake: a requester holds its req bit high until it sees its gnt bit;
// the grant lasts while req stays high and done stays low, bounded by
// MAX_HOLD. Dropping req or raising done ends the grant at that edge.
// ----------------------------------------------------------------------------
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    // Registered state
    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_gnt_vld;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_timeout;

    // Next-state values
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   w_gnt_idx_nxt;
    logic               w_gnt_vld_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               w_timeout_nxt;

    // Round-robin scan
    logic [NREQ-1:0]    w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_sel;

    // Exit conditions
    logic               w_own_req;
    logic               w_hold_max;
    logic               w_exit;

    // Rotate the request vector so bit 0 corresponds to requester r_ptr.
    // The lowest set bit of the rotated vector is then the first requester
    // at or above r_ptr, wrapping 15 -> 0.
    assign w_rot = NREQ'({req, req} >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    // 4-bit addition wraps 15 -> 0 naturally.
    assign w_sel = r_ptr + w_off;

    assign w_own_req  = req[r_gnt_idx];
    assign w_hold_max = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign w_exit     = done || !w_own_req || w_hold_max;

    // Next-state / output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_vld_nxt = r_gnt_vld;
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_gnt_vld_nxt = 1'b0;
                if (|req) begin
                    w_state_nxt   = S_GRANT;
                    w_gnt_idx_nxt = w_sel;
                    w_gnt_vld_nxt = 1'b1;
                    w_hold_nxt    = '0;
                end
            end
            S_GRANT: begin
                if (w_exit) begin
                    w_state_nxt   = S_IDLE;
                    w_gnt_vld_nxt = 1'b0;
                    w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
                    // Pulse only when the hold limit alone ended the grant.
                    w_timeout_nxt = !done && w_own_req;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_gnt_vld  <= 1'b0;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_gnt_vld  <= w_gnt_vld_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    dec4_16 u_dec (
        .a   (r_gnt_idx),
        .enn (r_gnt_vld),
        .d   (gnt)
    );

    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule : rr_arb16

// File: tb/tb_rr_arb16.sv
// ----------------------------------------------------------------------------
// tb_rr_arb16
// Directed checks of the round-robin arbiter, built with MAX_HOLD = 4.
// Inputs change 1 time unit after a rising edge; outputs are observed there,
// i.e. they reflect the register update made by that edge.
// ----------------------------------------------------------------------------
module tb_rr_arb16;
    import rr_arb16_pkg::*;

    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic             done;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    int checks;
    int errors;

    rr_arb16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; afterwards outputs show the new register values.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset values
    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset: gnt=%h vld=%b to=%b idx=%0d, want gnt=0000 vld=0 to=0 idx=0",
                     gnt, gnt_vld, timeout, gnt_idx);
        end
    endtask

    // Single requester released by done on its third grant cycle
    task automatic test_single_done();
        do_reset();
        req = 16'h0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (gnt !== 16'h0001 || gnt_idx !== 4'd0 || gnt_vld !== 1'b1) begin
                errors++;
                $display("FAIL single_grant c%0d: gnt=%h idx=%0d vld=%b, want gnt=0001 idx=0 vld=1",
                         c, gnt, gnt_idx, gnt_vld);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        checks++;
        if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%h vld=%b to=%b, want gnt=0000 vld=0 to=0",
                     gnt, gnt_vld, timeout);
        end
        checks++;
        if (dut.r_ptr !== 4'd1) begin
            errors++;
            $display("FAIL single_ptr: ptr=%0d, want 1", dut.r_ptr);
        end
    endtask

    // Two persistent requesters alternate with a gap between grants
    task automatic test_back_to_back();
        logic [3:0] exp_idx [4];
        exp_idx[0] = 4'd0;
        exp_idx[1] = 4'd15;
        exp_idx[2] = 4'd0;
        exp_idx[3] = 4'd15;
        do_reset();
        req = 16'h8001;
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++;
            if (gnt !== (16'h0001 << exp_idx[g]) || gnt_idx !== exp_idx[g]) begin
                errors++;
                $display("FAIL b2b_grant%0d: gnt=%h idx=%0d, want idx=%0d", g, gnt, gnt_idx, exp_idx[g]);
            end
            tick();
            checks++;
            if (gnt_idx !== exp_idx[g] || gnt_vld !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold%0d: idx=%0d vld=%b, want idx=%0d vld=1", g, gnt_idx, gnt_vld, exp_idx[g]);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt !== 16'h0000) begin
                errors++;
                $display("FAIL b2b_gap%0d: gnt=%h, want 0000", g, gnt);
            end
        end
        req = '0;
        tick();
    endtask

    // Pointer wrap-around: ptr moved to 14, then 14 -> 0 -> 2
    task automatic test_wrap();
        logic [3:0] exp_idx [3];
        exp_idx[0] = 4'd14;
        exp_idx[1] = 4'd0;
        exp_idx[2] = 4'd2;
        do_reset();
        req = 16'h2000;
        tick();
        checks++;
        if (gnt_idx !== 4'd13 || gnt !== 16'h2000) begin
            errors++;
            $display("FAIL wrap_setup: gnt=%h idx=%0d, want gnt=2000 idx=13", gnt, gnt_idx);
        end
        done = 1'b1;
        req  = 16'h4005;
        tick();
        done = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (gnt !== (16'h0001 << exp_idx[g]) || gnt_idx !== exp_idx[g]) begin
                errors++;
                $display("FAIL wrap_grant%0d: gnt=%h idx=%0d, want idx=%0d", g, gnt, gnt_idx, exp_idx[g]);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req = '0;
        tick();
    endtask

    // Forced revoke after MAX_HOLD cycles; done on the last cycle suppresses timeout
    task automatic test_timeout();
        do_reset();
        req = 16'h0010;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            checks++;
            if (gnt !== 16'h0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold c%0d: gnt=%h to=%b, want gnt=0010 to=0", c, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 16'h0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: gnt=%h to=%b, want gnt=0000 to=1", gnt, timeout);
        end
        tick();
        checks++;
        if (gnt !== 16'h0010 || gnt_idx !== 4'd4 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_regrant: gnt=%h idx=%0d to=%b, want gnt=0010 idx=4 to=0", gnt, gnt_idx, timeout);
        end
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 16'h0010) begin
            errors++;
            $display("FAIL to_last_cycle: gnt=%h, want 0010", gnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        checks++;
        if (gnt !== 16'h0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_done_priority: gnt=%h to=%b, want gnt=0000 to=0", gnt, timeout);
        end
        tick();
    endtask

    // Grantee abandons; other requester served after one idle cycle
    task automatic test_abandon();
        do_reset();
        req = 16'h0008;
        tick();
        checks++;
        if (gnt !== 16'h0008 || gnt_idx !== 4'd3) begin
            errors++;
            $display("FAIL ab_grant: gnt=%h idx=%0d, want gnt=0008 idx=3", gnt, gnt_idx);
        end
        req = 16'h0208;
        tick();
        checks++;
        if (gnt !== 16'h0008) begin
            errors++;
            $display("FAIL ab_ignore_other: gnt=%h, want 0008", gnt);
        end
        req = 16'h0200;
        tick();
        checks++;
        if (gnt !== 16'h0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL ab_release: gnt=%h to=%b, want gnt=0000 to=0", gnt, timeout);
        end
        tick();
        checks++;
        if (gnt !== 16'h0200 || gnt_idx !== 4'd9) begin
            errors++;
            $display("FAIL ab_next: gnt=%h idx=%0d, want gnt=0200 idx=9", gnt, gnt_idx);
        end
        req = '0;
        tick();
    endtask

    // Reset during a grant revokes it and restarts the pointer at 0
    task automatic test_reset_mid_grant();
        do_reset();
        req = 16'h0100;
        tick();
        checks++;
        if (gnt !== 16'h0100) begin
            errors++;
            $display("FAIL rm_grant: gnt=%h, want 0100", gnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rm_revoke: gnt=%h vld=%b to=%b, want gnt=0000 vld=0 to=0", gnt, gnt_vld, timeout);
        end
        rst = 1'b0;
        req = 16'h0900;
        tick();
        checks++;
        if (gnt !== 16'h0100 || gnt_idx !== 4'd8 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rm_restart: gnt=%h idx=%0d to=%b, want gnt=0100 idx=8 to=0", gnt, gnt_idx, timeout);
        end
        req = '0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = '0;
        done   = 1'b0;
        test_reset();
        test_single_done();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_abandon();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on simulation time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_rr_arb16

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum grant cycles before forced revoke; legal range 1..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  16  request vector; bit i is requester i.
REQ-005 SHALL have port done  input  1  current grantee releases the resource; ignored unless state is GRANT.
REQ-006 SHALL have port gnt  output  16  one-hot grant vector; all zero when no grant is held.
REQ-007 SHALL have port gnt_idx  output  4  binary index of the current grantee, registered.
REQ-008 SHALL have port gnt_vld  output  1  a grant is held, registered.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse after a forced revoke, registered.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 In IDLE with req != 0, SHALL select the first set req bit at or above ptr, searching upward and wrapping 15 -> 0.
REQ-012 On that edge, SHALL load gnt_idx with the selected index, set gnt_vld=1 and enter GRANT; grant latency is 1 cycle from req.
REQ-013 In IDLE with req == 0, SHALL stay in IDLE with gnt_vld=0.
REQ-014 SHALL derive gnt combinationally from gnt_idx, using gnt_vld as the enable; exactly one bit is set when gnt_vld=1, else all zero.
REQ-015 SHALL reset hold_cnt to 0 on GRANT entry and increment it on every GRANT cycle that does not exit.
REQ-016 In GRANT, SHALL exit to IDLE at the edge where any of these holds:
- done=1;
- req[gnt_idx]=0, treated as abandon;
- hold_cnt == MAX_HOLD-1.
REQ-017 On exit, SHALL clear gnt_vld and set ptr = gnt_idx+1, wrapping 15 -> 0.
REQ-018 SHALL hold gnt_idx at its last value while in IDLE; its value there is don't-care for consumers.
REQ-019 SHALL assert timeout for exactly the one cycle after an exit caused only by hold_cnt == MAX_HOLD-1.
- That cycle has done=0 and req[gnt_idx]=1.
- A grant therefore lasts at most MAX_HOLD cycles.
REQ-020 Exit conditions SHALL have priority done > abandon > timeout; timeout is not pulsed if done or abandon coincide.
REQ-021 After any exit, SHALL spend exactly one cycle in IDLE before the next grant.
- Back-to-back grants to different requesters are separated by one gnt=0 cycle.
REQ-022 A requester whose grant ended SHALL be re-granted only after all other pending requesters have been served (round-robin fairness).
REQ-023 A single persistent requester SHALL be re-granted every second cycle window (grant, idle, grant).
REQ-024 Changes to req bits other than req[gnt_idx] during GRANT SHALL have no effect until the next IDLE cycle.
REQ-025 MAX_HOLD=1 SHALL yield single-cycle grants, with timeout pulsed whenever done=0 and the request persists.

Reset
REQ-026 When rst=1 at a clock edge, SHALL set state=IDLE, ptr=0, gnt_idx=0, gnt_vld=0, hold_cnt=0 and timeout=0.
- gnt is therefore 0 from the next cycle.
REQ-027 Reset mid-grant SHALL revoke the grant without a timeout pulse; ptr restarts at 0.
REQ-028 SHALL accept the first grant on the first edge after rst deasserts.

Structure
REQ-029 SHALL place the following in a shared package: the FSM state typedef (IDLE, GRANT), the constant NREQ=16 and the index width 4.
REQ-030 SHALL instantiate the existing dec4_16 decoder as its one sub-module: a=gnt_idx, enn=gnt_vld, d=gnt.
REQ-031 SHALL implement the round-robin search as a combinational priority scan over a rotated request vector.
- The scan lives in the arbiter, not in a separate module.
REQ-032 SHALL keep hold_cnt 8 bits wide.

Verification
REQ-033 Reset then req=16'h0001, done=1 on cycle 3 -> gnt=16'h0001, gnt_idx=0 from cycle 1; gnt=0 on cycle 4; ptr=1.
REQ-034 req=16'h8001 held, done=1 on each grant's second cycle -> grants alternate idx 0, 15, 0, 15, with a one-cycle gnt=0 gap between each.
REQ-035 ptr=14, req=16'h4005 -> grant order is idx 14, then 0, then 2 (wrap-around).
REQ-036 MAX_HOLD=4, req=16'h0010 held, done=0 -> gnt=16'h0010 for exactly 4 cycles, then timeout=1 for 1 cycle, then re-grant to idx 4.
REQ-037 Grantee idx 3 drops req[3] mid-grant, req[9]=1 -> gnt clears next edge, no timeout, idx 9 granted after one IDLE cycle.
REQ-038 rst=1 while gnt=16'h0100 -> gnt=0 next cycle; timeout stays 0; next grant search starts from idx 0.
